// File: rtl/disk_sector_pump.sv
// Sector pump between a floppy-style drive port and a host byte stream.
// Reads are filled from the host and then strobed to the drive; writes are collected from the drive and then drained to the host.
module disk_sector_pump #(
  parameter int SECTOR_BYTES = 512,
  parameter int GAP          = 3
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr,
  output logic [7:0]  disk_data_in,
  output logic        disk_data_clkin,
  input  logic [7:0]  disk_data_out,
  input  logic        disk_data_clkout,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [7:0]  req_track,
  output logic [7:0]  req_sector,
  output logic        req_side,
  output logic        req_drive,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        host_err,
  output logic        busy
);

  localparam int IW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SECTOR_BYTES - 1);
  localparam logic [3:0] GAP_W = 4'(GAP);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_FILL    = 3'd2;
  localparam logic [2:0] S_FEED    = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic [7:0]    buf_q [SECTOR_BYTES];
  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    gap_q, gap_d;
  logic          last_q, last_d;
  logic          clkin_q, clkin_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    cr_q, cr_d;
  logic          write_q, write_d;
  logic [7:0]    track_q, track_d, sector_q, sector_d;
  logic          side_q, side_d, drive_q, drive_d;
  logic          prev_clkout_q;
  logic          req_bit, rise, we;
  logic [7:0]    wdata;
  logic          unused_sr;

  assign unused_sr = ^{disk_sr[31:26], disk_sr[7:2]};
  assign req_bit   = write_q ? disk_sr[1] : disk_sr[0];
  assign rise      = disk_data_clkout & ~prev_clkout_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    last_d   = last_q;
    clkin_d  = 1'b0;
    data_d   = data_q;
    cr_d     = cr_q;
    write_d  = write_q;
    track_d  = track_q;
    sector_d = sector_q;
    side_d   = side_q;
    drive_d  = drive_q;
    we       = 1'b0;
    wdata    = rx_data;
    case (state_q)
      S_IDLE: begin
        if (disk_sr[0] || disk_sr[1]) begin
          track_d  = disk_sr[15:8];
          sector_d = disk_sr[23:16];
          side_d   = disk_sr[24];
          drive_d  = disk_sr[25];
          write_d  = ~disk_sr[0];
          idx_d    = '0;
          state_d  = disk_sr[0] ? S_REQ : S_COLLECT;
        end
      end
      S_REQ: begin
        if (!req_bit) state_d = S_IDLE;
        else if (host_err) begin
          state_d = S_ERR;
          cr_d    = 3'b100;
        end else if (req_ready) begin
          state_d = write_q ? S_DRAIN : S_FILL;
          idx_d   = '0;
        end
      end
      S_FILL: begin
        if (!req_bit) state_d = S_IDLE;
        else if (host_err) begin
          state_d = S_ERR;
          cr_d    = 3'b100;
        end else if (rx_valid) begin
          we = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_FEED;
            idx_d   = '0;
            gap_d   = '0;
            last_d  = 1'b0;
          end else idx_d = idx_q + 1'b1;
        end
      end
      S_FEED: begin
        // last_q is checked first so DONE is entered the cycle after the final strobe
        if (!req_bit) state_d = S_IDLE;
        else if (last_q) begin
          state_d = S_DONE;
          cr_d    = 3'b001;
          idx_d   = '0;
        end else if (gap_q != '0) gap_d = gap_q - 1'b1;
        else begin
          clkin_d = 1'b1;
          data_d  = buf_q[idx_q];
          gap_d   = GAP_W;
          if (idx_q == LAST) last_d = 1'b1;
          else idx_d = idx_q + 1'b1;
        end
      end
      S_COLLECT: begin
        if (!req_bit) state_d = S_IDLE;
        else if (rise) begin
          we    = 1'b1;
          wdata = disk_data_out;
          if (idx_q == LAST) begin
            state_d = S_REQ;
            idx_d   = '0;
          end else idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!req_bit) state_d = S_IDLE;
        else if (host_err) begin
          state_d = S_ERR;
          cr_d    = 3'b100;
        end else if (tx_ready) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
            cr_d    = 3'b010;
            idx_d   = '0;
          end else idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        if (disk_sr[1:0] == 2'b00) begin
          state_d = S_IDLE;
          cr_d    = '0;
        end
      end
    endcase
    if (state_d == S_IDLE && state_q != S_IDLE) idx_d = '0;
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      gap_q         <= '0;
      last_q        <= 1'b0;
      clkin_q       <= 1'b0;
      data_q        <= '0;
      cr_q          <= '0;
      write_q       <= 1'b0;
      track_q       <= '0;
      sector_q      <= '0;
      side_q        <= 1'b0;
      drive_q       <= 1'b0;
      prev_clkout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      last_q        <= last_d;
      clkin_q       <= clkin_d;
      data_q        <= data_d;
      cr_q          <= cr_d;
      write_q       <= write_d;
      track_q       <= track_d;
      sector_q      <= sector_d;
      side_q        <= side_d;
      drive_q       <= drive_d;
      prev_clkout_q <= disk_data_clkout;
    end
  end

  always_ff @(posedge clk24) begin
    if (we) buf_q[idx_q] <= wdata;
  end

  assign disk_cr         = {29'd0, cr_q};
  assign disk_data_in    = data_q;
  assign disk_data_clkin = clkin_q;
  assign req_valid       = (state_q == S_REQ);
  assign req_write       = write_q;
  assign req_track       = track_q;
  assign req_sector      = sector_q;
  assign req_side        = side_q;
  assign req_drive       = drive_q;
  assign rx_ready        = (state_q == S_FILL);
  assign tx_valid        = (state_q == S_DRAIN);
  assign tx_data         = buf_q[idx_q];
  assign busy            = (state_q != S_IDLE);

endmodule
